// File: rtl/audio_pkg.sv
// Shared audio-path definitions: default sample width, PWM window length and midscale helper.
package audio_pkg;

    localparam int AUDIO_SAMPLE_W          = 14;
    localparam int AUDIO_CYCLES_PER_WINDOW = 1024;

    typedef logic signed [AUDIO_SAMPLE_W-1:0] audio_sample_t;

    // Duty value that produces a 50% waveform, i.e. silence at the audio pin.
    function automatic int duty_midscale(input int cycles);
        return cycles / 2;
    endfunction

endpackage

// File: rtl/audio_pwm_dac_sample_to_duty.sv
// Combinational conversion of a two's-complement sample into an offset-binary PWM duty value.
// Optional volume shift is built only when AUDIO_PWM_VOLUME_EN is defined.
module sample_to_duty
    import audio_pkg::*;
#(
    parameter int SAMPLE_W = AUDIO_SAMPLE_W,
    parameter int DUTY_W   = 10
) (
    input  logic [SAMPLE_W-1:0] sample,
`ifdef AUDIO_PWM_VOLUME_EN
    input  logic [3:0]          volume,
`endif
    output logic [DUTY_W-1:0]   duty
);

    logic signed [SAMPLE_W-1:0] shifted;

    // Flipping the sign bit maps -full..+full onto 0..2^SAMPLE_W-1; the top bits become the duty.
    always_comb begin
`ifdef AUDIO_PWM_VOLUME_EN
        shifted = $signed(sample) >>> volume;
`else
        shifted = $signed(sample);
`endif
        duty = DUTY_W'({~shifted[SAMPLE_W-1], shifted[SAMPLE_W-2:0]} >> (SAMPLE_W - DUTY_W));
    end

endmodule

// File: rtl/audio_pwm_dac.sv
// PWM audio DAC: free-running window counter, per-window sample request/latch and PWM compare.
// Define AUDIO_PWM_VOLUME_EN to add the 4-bit volume attenuation port.
module audio_pwm_dac
    import audio_pkg::*;
#(
    parameter int CYCLES_PER_WINDOW = AUDIO_CYCLES_PER_WINDOW,
    parameter int SAMPLE_W          = AUDIO_SAMPLE_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample,
`ifdef AUDIO_PWM_VOLUME_EN
    input  logic [3:0]          volume,
`endif
    output logic                next_sample,
    output logic                pwm_out
);

    localparam int DUTY_W = $clog2(CYCLES_PER_WINDOW);
    localparam logic [DUTY_W-1:0] CNT_LAST   = DUTY_W'(CYCLES_PER_WINDOW - 1);
    localparam logic [DUTY_W-1:0] CNT_STROBE = DUTY_W'(CYCLES_PER_WINDOW - 2);
    localparam logic [DUTY_W-1:0] DUTY_MID   = DUTY_W'(duty_midscale(CYCLES_PER_WINDOW));

    logic [DUTY_W-1:0] cnt;
    logic [DUTY_W-1:0] duty;
    logic [DUTY_W-1:0] duty_next;

    sample_to_duty #(
        .SAMPLE_W (SAMPLE_W),
        .DUTY_W   (DUTY_W)
    ) u_conv (
        .sample (sample),
`ifdef AUDIO_PWM_VOLUME_EN
        .volume (volume),
`endif
        .duty   (duty_next)
    );

    // Strobe one cycle early so the NCO's new sample is settled by the latch cycle.
    assign next_sample = (cnt == CNT_STROBE);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            duty    <= DUTY_MID;
            pwm_out <= 1'b0;
        end else begin
            cnt     <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
                duty <= duty_next;
            end
            pwm_out <= (cnt < duty);
        end
    end

endmodule

// File: tb/tb_audio_pwm_dac.sv
// Scoreboard bench for audio_pwm_dac with a 16-cycle window and a behavioural NCO model.
// Builds the volume checks when AUDIO_PWM_VOLUME_EN is defined.
module tb_audio_pwm_dac;
    import audio_pkg::*;

    localparam int CYC = 16;
    localparam int SW  = 14;

    typedef struct {
        logic pwm;
        logic ns;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [SW-1:0] sample = '0;
    logic          next_sample;
    logic          pwm_out;
`ifdef AUDIO_PWM_VOLUME_EN
    logic [3:0]    volume = 4'd0;
`endif

    logic [SW-1:0] nco_next = '0;
    logic [SW-1:0] poke_val = '0;
    logic          poke = 1'b0;

    exp_t exp_q[$];
    int   pos = 0;
    int   duty_m = CYC / 2;
    bit   model_on = 1'b0;
    int   strobe_cnt = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    audio_pwm_dac #(
        .CYCLES_PER_WINDOW (CYC),
        .SAMPLE_W          (SW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample      (sample),
`ifdef AUDIO_PWM_VOLUME_EN
        .volume      (volume),
`endif
        .next_sample (next_sample),
        .pwm_out     (pwm_out)
    );

    // NCO stand-in: presents the queued value after each strobe, or a forced value when poked.
    always @(posedge clk) begin
        if (poke)
            sample <= poke_val;
        else if (next_sample)
            sample <= nco_next;
    end

    function automatic int cur_vol();
`ifdef AUDIO_PWM_VOLUME_EN
        return int'(volume);
`else
        return 0;
`endif
    endfunction

    // Duty = attenuated sample moved to 0..16383, scaled to 0..CYC-1.
    function automatic int ref_duty(input logic [SW-1:0] s, input int v);
        int x;
        x = int'($signed(s));
        x = x >>> v;
        return (x + 8192) / (16384 / CYC);
    endfunction

    // Reference: each window is high for its first duty_m compares, delayed one cycle.
    always @(posedge clk) begin
        exp_t e;
        if (rst) begin
            model_on = 1'b1;
            pos      = 0;
            duty_m   = CYC / 2;
            e.pwm    = 1'b0;
        end else begin
            e.pwm = (pos < duty_m);
            if (pos == CYC - 1)
                duty_m = ref_duty(sample, cur_vol());
            pos = (pos + 1) % CYC;
        end
        e.ns = (pos == CYC - 2);
        if (model_on)
            exp_q.push_back(e);
    end

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %b want %b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %0d want %0d", name, $time, act, exp);
        end
    endtask

    // Monitor pops one expectation per cycle once the model has seen reset.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_bit("pwm_out", pwm_out, e.pwm);
            check_bit("next_sample", next_sample, e.ns);
            if (next_sample === 1'b1)
                strobe_cnt++;
        end
    end

    task automatic run_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pos(input int p);
        int guard;
        guard = 0;
        while (pos != p && guard < 2 * CYC) begin
            @(negedge clk);
            guard++;
        end
        check_int("wait_pos_reached", pos, p);
    endtask

    task automatic poke_sample(input logic [SW-1:0] v);
        poke_val = v;
        poke     = 1'b1;
        @(negedge clk);
        poke     = 1'b0;
    endtask

    initial begin
        int s0;
        rst      = 1'b1;
        nco_next = 14'h0000;
        run_cycles(3);
        rst = 1'b0;

        s0 = strobe_cnt;
        run_cycles(10 * CYC);
        check_int("strobes_in_10_windows", strobe_cnt - s0, 10);

        nco_next = 14'h1FFF;
        run_cycles(3 * CYC);
        nco_next = 14'h2000;
        run_cycles(3 * CYC);

        nco_next = 14'h0000;
        run_cycles(2 * CYC);
        wait_pos(4);
        nco_next = 14'h1000;
        poke_sample(14'h1000);
        run_cycles(2 * CYC);

        nco_next = 14'h1FFF;
        run_cycles(2 * CYC);
        wait_pos(5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_int("cnt_after_reset", int'(dut.cnt), 0);
        check_int("duty_after_reset", int'(dut.duty), CYC / 2);
        run_cycles(2 * CYC);

`ifdef AUDIO_PWM_VOLUME_EN
        nco_next = 14'h1FFF;
        volume   = 4'd1;
        run_cycles(3 * CYC);
        volume   = 4'd15;
        run_cycles(3 * CYC);
        volume   = 4'd0;
`endif

        for (int i = 0; i < 40; i++) begin
            nco_next = 14'($urandom_range(0, 16383));
`ifdef AUDIO_PWM_VOLUME_EN
            volume = 4'($urandom_range(0, 15));
`endif
            run_cycles($urandom_range(3, 20));
            if ($urandom_range(0, 3) == 0)
                poke_sample(14'($urandom_range(0, 16383)));
            if ($urandom_range(0, 15) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end

        run_cycles(CYC);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

endmodule
